// File: rtl/beam_thresh_loader.sv
// Shadow threshold table for the beamformer trigger bank; shifts the table into the
// DSP cascade (last beam first) on request, then pulses update so all beams switch together.
module beam_thresh_loader #(
    parameter int                  NBEAMS         = 2,
    parameter int                  THR_BITS       = 18,
    parameter logic [THR_BITS-1:0] DEFAULT_THRESH = 18'h3FFFF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        thr_wr_i,
    input  logic [$clog2(NBEAMS)-1:0]   thr_addr_i,
    input  logic                        thr_sel_i,
    input  logic [THR_BITS-1:0]         thr_dat_i,
    input  logic [1:0]                  start_i,
    output logic                        busy_o,
    output logic                        pending_o,
    output logic                        done_o,
    output logic [2*THR_BITS-1:0]       thresh_o,
    output logic [1:0]                  thresh_wr_o,
    output logic [1:0]                  thresh_update_o
);
    localparam int              AW       = $clog2(NBEAMS);
    localparam logic [AW:0]     BEAM_CNT = (AW+1)'(NBEAMS);
    localparam logic [AW-1:0]   LAST     = AW'(NBEAMS - 1);
    localparam logic [AW-1:0]   ONE      = AW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, UPDATE} state_t;

    state_t                                 state_q, state_d;
    logic [AW-1:0]                          idx_q, idx_d, rd_idx;
    logic [1:0]                             mask_q, mask_d, pend_q, pend_d, req, beat_mask;
    logic [1:0][NBEAMS-1:0][THR_BITS-1:0]   shadow;
    logic                                   busy_d, done_d;
    logic [1:0]                             upd_d;
    logic [THR_BITS-1:0]                    th_lo, th_hi;

    // Shadow table; out-of-range beam addresses are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int h = 0; h < 2; h++)
                for (int b = 0; b < NBEAMS; b++)
                    shadow[h][b] <= DEFAULT_THRESH;
        end else if (thr_wr_i && ({1'b0, thr_addr_i} < BEAM_CNT)) begin
            shadow[thr_sel_i][thr_addr_i] <= thr_dat_i;
        end
    end

    // idx_q is the beam currently on the cascade; the next beam is read one edge ahead
    // so that every output leaves a flop.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        pend_d    = pend_q;
        rd_idx    = idx_q;
        beat_mask = 2'b00;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        upd_d     = 2'b00;
        req       = start_i | pend_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d   = LOAD;
                    mask_d    = req;
                    pend_d    = 2'b00;
                    idx_d     = LAST;
                    rd_idx    = LAST;
                    beat_mask = req;
                    busy_d    = 1'b1;
                end
            end
            LOAD: begin
                pend_d = pend_q | start_i;
                busy_d = 1'b1;
                if (idx_q == '0) begin
                    state_d = UPDATE;
                    upd_d   = mask_q;
                end else begin
                    idx_d     = idx_q - ONE;
                    rd_idx    = idx_q - ONE;
                    beat_mask = mask_q;
                end
            end
            UPDATE: begin
                pend_d  = pend_q | start_i;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        th_lo = beat_mask[0] ? shadow[0][rd_idx] : {THR_BITS{1'b0}};
        th_hi = beat_mask[1] ? shadow[1][rd_idx] : {THR_BITS{1'b0}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            mask_q          <= 2'b00;
            pend_q          <= 2'b00;
            busy_o          <= 1'b0;
            pending_o       <= 1'b0;
            done_o          <= 1'b0;
            thresh_o        <= '0;
            thresh_wr_o     <= 2'b00;
            thresh_update_o <= 2'b00;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            mask_q          <= mask_d;
            pend_q          <= pend_d;
            busy_o          <= busy_d;
            pending_o       <= |pend_d;
            done_o          <= done_d;
            thresh_o        <= {th_hi, th_lo};
            thresh_wr_o     <= beat_mask;
            thresh_update_o <= upd_d;
        end
    end
endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench: NBEAMS=4 instance for the main flows, NBEAMS=6 instance so an
// out-of-range beam address is representable.
module tb_beam_thresh_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        thr_wr, thr_sel;
    logic [1:0]  thr_addr;
    logic [17:0] thr_dat;
    logic [1:0]  start;
    logic        busy, pending, done;
    logic [35:0] thresh;
    logic [1:0]  wr, upd;

    logic        thr_wr6, thr_sel6;
    logic [2:0]  thr_addr6;
    logic [17:0] thr_dat6;
    logic [1:0]  start6;
    logic        busy6, pending6, done6;
    logic [35:0] thresh6;
    logic [1:0]  wr6, upd6;

    int checks = 0;
    int errors = 0;
    logic [35:0] e;
    int seen;

    always #5 clk = ~clk;

    beam_thresh_loader #(.NBEAMS(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .thr_wr_i(thr_wr), .thr_addr_i(thr_addr),
        .thr_sel_i(thr_sel), .thr_dat_i(thr_dat), .start_i(start), .busy_o(busy),
        .pending_o(pending), .done_o(done), .thresh_o(thresh), .thresh_wr_o(wr),
        .thresh_update_o(upd)
    );

    beam_thresh_loader #(.NBEAMS(6)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .thr_wr_i(thr_wr6), .thr_addr_i(thr_addr6),
        .thr_sel_i(thr_sel6), .thr_dat_i(thr_dat6), .start_i(start6), .busy_o(busy6),
        .pending_o(pending6), .done_o(done6), .thresh_o(thresh6), .thresh_wr_o(wr6),
        .thresh_update_o(upd6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_entry(input logic [1:0] a, input logic s, input logic [17:0] d);
        thr_wr = 1'b1; thr_addr = a; thr_sel = s; thr_dat = d;
        tick();
        thr_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        thr_wr = 0; thr_sel = 0; thr_addr = 0; thr_dat = 0; start = 0;
        thr_wr6 = 0; thr_sel6 = 0; thr_addr6 = 0; thr_dat6 = 0; start6 = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_done", done, 0);
        chk("rst_thresh", thresh, 0);
        chk("rst_wr", wr, 0);
        chk("rst_upd", upd, 0);
        chk("rst_dut6_outs", {busy6, pending6, done6, thresh6, wr6, upd6}, 0);
        rst_n = 1'b1;
        tick();

        // Reset defaults cascade
        start = 2'b11;
        tick();
        start = 2'b00;
        for (int j = 0; j < 4; j++) begin
            chk("def_thresh", thresh, 36'hF_FFFF_FFFF);
            chk("def_wr", wr, 2'b11);
            chk("def_busy", busy, 1);
            chk("def_upd_low", upd, 0);
            tick();
        end
        chk("def_upd", upd, 2'b11);
        chk("def_upd_wr", wr, 0);
        chk("def_upd_thresh", thresh, 0);
        chk("def_upd_busy", busy, 1);
        chk("def_upd_done", done, 0);
        tick();
        chk("def_done", done, 1);
        chk("def_done_busy", busy, 0);
        chk("def_done_upd", upd, 0);
        tick();
        chk("def_done_pulse", done, 0);

        // Ordering
        for (int b = 0; b < 4; b++) begin
            wr_entry(2'(b), 1'b0, 18'h100 + 18'(b));
            wr_entry(2'(b), 1'b1, 18'h200 + 18'(b));
        end
        start = 2'b01;
        tick();
        start = 2'b00;
        for (int j = 0; j < 4; j++) begin
            e = 36'h103 - 36'(j);
            chk("ord_thresh", thresh, e);
            chk("ord_wr", wr, 2'b01);
            tick();
        end
        chk("ord_upd", upd, 2'b01);
        tick();
        chk("ord_done", done, 1);
        tick();

        // Queued start on beat 2
        start = 2'b01;
        tick();
        start = 2'b00;
        tick();
        chk("q_beat2_thresh", thresh, 36'h102);
        chk("q_pend_before", pending, 0);
        start = 2'b10;
        tick();
        start = 2'b00;
        chk("q_pend_set", pending, 1);
        chk("q_beat3_thresh", thresh, 36'h101);
        tick();
        chk("q_beat4_thresh", thresh, 36'h100);
        tick();
        chk("q_upd1", upd, 2'b01);
        chk("q_upd1_pend", pending, 1);
        tick();
        chk("q_done1", done, 1);
        chk("q_done1_busy", busy, 0);
        chk("q_done1_pend", pending, 1);
        chk("q_done1_wr", wr, 0);
        tick();
        chk("q_load2_busy", busy, 1);
        chk("q_load2_done", done, 0);
        chk("q_pend_clear", pending, 0);
        for (int j = 0; j < 4; j++) begin
            e = (36'h203 - 36'(j)) << 18;
            chk("q_load2_thresh", thresh, e);
            chk("q_load2_wr", wr, 2'b10);
            tick();
        end
        chk("q_upd2", upd, 2'b10);
        tick();
        chk("q_done2", done, 1);
        tick();

        // Collisions
        start = 2'b01;
        tick();
        start = 2'b00;
        chk("col_b3", thresh, 36'h103);
        tick();
        chk("col_b2", thresh, 36'h102);
        thr_wr = 1'b1; thr_addr = 2'd0; thr_sel = 1'b0; thr_dat = 18'h55;
        tick();
        chk("col_b1_old", thresh, 36'h101);
        thr_addr = 2'd1; thr_dat = 18'h3;
        tick();
        thr_wr = 1'b0;
        chk("col_b0_new", thresh, 36'h55);
        tick();
        chk("col_upd", upd, 2'b01);
        tick();
        chk("col_done", done, 1);
        // Write landing on the same edge that reads beam 2
        start = 2'b01;
        tick();
        start = 2'b00;
        thr_wr = 1'b1; thr_addr = 2'd2; thr_sel = 1'b0; thr_dat = 18'h77;
        chk("same_b3", thresh, 36'h103);
        tick();
        thr_wr = 1'b0;
        chk("same_b2_old", thresh, 36'h102);
        tick();
        chk("same_b1", thresh, 36'h3);
        tick();
        chk("same_b0", thresh, 36'h55);
        tick(); tick(); tick();

        // Reset mid-load
        start = 2'b11;
        tick();
        start = 2'b00;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, pending, done, thresh, wr, upd}, 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (upd != 2'b00 || done || busy) seen++;
        end
        chk("mid_rst_quiet", seen, 0);
        start = 2'b11;
        tick();
        start = 2'b00;
        for (int j = 0; j < 4; j++) begin
            chk("mid_rst_default", thresh, 36'hF_FFFF_FFFF);
            tick();
        end
        chk("mid_rst_upd", upd, 2'b11);
        tick(); tick();

        // Ignored inputs: empty start mask, out-of-range beam address
        start = 2'b00;
        seen = 0;
        thr_wr6 = 1'b1; thr_addr6 = 3'd6; thr_sel6 = 1'b0; thr_dat6 = 18'h00001;
        tick();
        thr_addr6 = 3'd5; thr_sel6 = 1'b1; thr_dat6 = 18'h12345;
        tick();
        thr_wr6 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy || done || wr != 2'b00 || busy6 || done6) seen++;
            tick();
        end
        chk("ign_start_quiet", seen, 0);
        start6 = 2'b11;
        tick();
        start6 = 2'b00;
        for (int j = 0; j < 6; j++) begin
            e = (j == 0) ? {18'h12345, 18'h3FFFF} : {18'h3FFFF, 18'h3FFFF};
            chk("ign_addr_thresh", thresh6, e);
            chk("ign_addr_wr", wr6, 2'b11);
            tick();
        end
        chk("ign_upd6", upd6, 2'b11);
        tick();
        chk("ign_done6", done6, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
